uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//   Receive side of the UART: recovers 8N1 bytes from the serial line driven by the transmitter.
//   Oversamples the asynchronous rx pin on the system clock, aligns to mid-bit and deserialises LSB-first.
//   Presents each byte as a one-cycle valid pulse to the downstream consumer; flags framing errors.
// PARAMETERS
//   CLKS_PER_BIT  434  clk cycles per bit (clk/baud, e.g. 50 MHz / 115200); must be >= 8
// PORTS
//   clk        in   1  system clock, rising edge
//   rst        in   1  synchronous, active-high reset
//   rx         in   1  asynchronous serial input, idle high
//   data_out   out  8  last correctly received byte; holds until next valid
//   valid      out  1  one-cycle pulse: data_out updated this cycle
//   frame_err  out  1  one-cycle pulse: stop bit sampled low
//   busy       out  1  high whenever state != IDLE
// BEHAVIOUR
//   - Reset: data_out=8'h00, valid=0, frame_err=0, busy=0, state=IDLE, sync flops=1, counters=0.
//   - Reset mid-frame: partial byte discarded, no valid/frame_err; next clock starts in IDLE.
//   - rx passes a 2-flop synchroniser (reset to 1); all decisions use the synchronised value rx_s.
//   - Bit counter cnt width $clog2(CLKS_PER_BIT); bit index idx 3 bits; shift register 8 bits.
//   - IDLE: busy=0; rx_s==0 -> START, cnt=0.
//   - START: cnt increments; at cnt==CLKS_PER_BIT/2-1: rx_s==0 -> DATA, cnt=0, idx=0;
//     rx_s==1 -> IDLE (false start, no flag).
//   - DATA: at cnt==CLKS_PER_BIT-1 sample (mid-bit), shift[idx]<=sample, cnt=0; idx==7 -> STOP, else idx+1.
//   - STOP: at cnt==CLKS_PER_BIT-1 sample: 1 -> data_out<=shift, valid=1, -> IDLE;
//     0 -> frame_err=1, data_out unchanged, -> WAIT_IDLE.
//   - WAIT_IDLE: stays until rx_s==1, then -> IDLE (line break never re-triggers a start).
//   - valid/frame_err never both high; each is high exactly one cycle per frame.
//   - Latency: valid rises 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT clocks after the rx falling edge.
//   - Back-to-back frames: return to IDLE at mid-stop-bit allows the next start edge to be caught.
//   - No buffering: consumer must capture data_out in the valid cycle (next frame overwrites it).
// CONFIGURATION
//   UART_RX_MAJORITY_EN defined: each bit decision (START check, DATA, STOP) is the 2-of-3 majority
//     of rx_s sampled at cnt==M-2, M-1, M (M = decision point above); single-cycle glitches rejected.
//   Not defined: single sample of rx_s at the decision point. Latency identical in both builds.
// STRUCTURE
//   - uart_pkg: rx state typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE};
//     UART_DATA_BITS=8; shared with the transmitter's state encoding.
//   - Sub-module uart_rx_sync: 2-flop synchroniser (clk, rst, d, q), reset value 1.
//   - Everything else (FSM, counters, shift register, majority voter) lives in uart_rx.
// TESTING  (CLKS_PER_BIT=16 in bench)
//   1. Frame 0xA5 (start,1,0,1,0,0,1,0,1,stop) -> one valid, data_out=0xA5, frame_err=0, busy low after.
//   2. Back-to-back 0x00 then 0xFF, no idle gap -> two valids, data_out 0x00 then 0xFF.
//   3. rx low for 4 clocks while idle -> no valid/frame_err; busy high 8+2 clocks max then 0.
//   4. 0x3C with stop bit low, rx held low 40 clocks -> one frame_err, no valid, data_out unchanged,
//      busy high until rx returns high, then 0x11 frame received correctly.
//   5. rst pulsed during data bit 4 of 0x77 -> outputs reset next cycle; following 0x5A received correctly.
//   6. 0x00 with 1-clock high glitch at bit-2 sample point -> MAJORITY_EN: data_out=0x00; else 0x04.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
// Module : uart_pkg
// Brief  : Shared UART definitions: state encoding, data width, majority vote.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } uart_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
// Module : uart_rx_sync
// Brief  : Two-flop synchroniser for the asynchronous rx pin, resets to idle (1).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module : uart_rx
// Brief  : 8N1 UART receiver, mid-bit sampling; optional 2-of-3 bit voting
//          enabled by defining UART_RX_MAJORITY_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int                  c_CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [c_CNT_W-1:0]  c_HALF_LAST = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_CNT_W-1:0]  c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]          c_IDX_LAST  = 3'(UART_DATA_BITS - 1);

  logic                      w_rx_s;
  logic                      w_sample;
  logic [1:0]                r_hist;

  uart_state_e               r_state, w_state_nxt;
  logic [c_CNT_W-1:0]        r_cnt, w_cnt_nxt;
  logic [2:0]                r_idx, w_idx_nxt;
  logic [UART_DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic [UART_DATA_BITS-1:0] r_data, w_data_nxt;
  logic                      r_valid, w_valid_nxt;
  logic                      r_ferr, w_ferr_nxt;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (w_rx_s)
  );

  // r_hist holds rx_s from the two cycles before the decision point
`ifdef UART_RX_MAJORITY_EN
  assign w_sample = maj3(r_hist[1], r_hist[0], w_rx_s);
`else
  assign w_sample = w_rx_s;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_hist  <= 2'b11;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_ferr  <= w_ferr_nxt;
      r_hist  <= {r_hist[0], w_rx_s};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt = START;
          w_cnt_nxt   = '0;
        end
      end
      START: begin
        if (r_cnt == c_HALF_LAST) begin
          w_cnt_nxt = '0;
          w_idx_nxt = '0;
          w_state_nxt = w_sample ? IDLE : DATA;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      DATA: begin
        if (r_cnt == c_BIT_LAST) begin
          w_shift_nxt[r_idx] = w_sample;
          w_cnt_nxt          = '0;
          if (r_idx == c_IDX_LAST) begin
            w_state_nxt = STOP;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      STOP: begin
        if (r_cnt == c_BIT_LAST) begin
          w_cnt_nxt = '0;
          if (w_sample) begin
            w_data_nxt  = r_shift;
            w_valid_nxt = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = WAIT_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      // A held-low line (break) must go high before a new start is accepted
      WAIT_IDLE: begin
        if (w_rx_s) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign data_out  = r_data;
  assign valid     = r_valid;
  assign frame_err = r_ferr;
  assign busy      = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module : tb_uart_rx
// Brief  : Directed self-checking bench for uart_rx at 16 clocks per bit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx;

  localparam int CPB   = 16;
  localparam int c_LAT = 2 + CPB / 2 + 9 * CPB;
`ifdef UART_RX_MAJORITY_EN
  localparam logic [7:0] c_GLITCH_EXP = 8'h00;
`else
  localparam logic [7:0] c_GLITCH_EXP = 8'h04;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int vectors = 0;
  int errs    = 0;
  int cyc     = 0;
  int n_valid = 0;
  int n_ferr  = 0;
  int valid_cyc = 0;
  int busy_cnt  = 0;
  bit busy_meas = 1'b0;
  logic [7:0] vlog [0:31];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data_out  (data_out),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture one-cycle pulses so the linear stimulus can check them afterwards
  always @(negedge clk) begin
    if (!rst) begin
      if (valid) begin
        vlog[n_valid[4:0]] = data_out;
        n_valid   = n_valid + 1;
        valid_cyc = cyc;
      end
      if (frame_err) n_ferr = n_ferr + 1;
      if (busy_meas && busy) busy_cnt = busy_cnt + 1;
      assert (!(valid && frame_err)) else begin
        errs = errs + 1;
        $error("FAIL excl: valid=%0b frame_err=%0b required not both high", valid, frame_err);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      errs = errs + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(1'b1);
  endtask

  int t_fall;
  int v0;
  int f0;
  logic [7:0] glitch_byte;

  initial begin
    glitch_byte = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_data", {24'd0, data_out}, 32'h00);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_ferr", {31'd0, frame_err}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 1: single frame 0xA5 with latency measurement
    t_fall = cyc;
    send_byte(8'hA5);
    repeat (4) @(negedge clk);
    check("t1_nvalid", n_valid, 1);
    check("t1_data", {24'd0, vlog[0]}, 32'hA5);
    check("t1_ferr", n_ferr, 0);
    check("t1_busy", {31'd0, busy}, 32'd0);
    check("t1_latency", valid_cyc - (t_fall + 1), c_LAT);

    // 2: back-to-back frames
    send_byte(8'h00);
    send_byte(8'hFF);
    repeat (4) @(negedge clk);
    check("t2_nvalid", n_valid, 3);
    check("t2_first", {24'd0, vlog[1]}, 32'h00);
    check("t2_second", {24'd0, vlog[2]}, 32'hFF);

    // 3: false start, 4-clock low pulse
    busy_cnt  = 0;
    busy_meas = 1'b1;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    busy_meas = 1'b0;
    check("t3_busy_cycles", busy_cnt, 8);
    check("t3_busy_end", {31'd0, busy}, 32'd0);
    check("t3_nvalid", n_valid, 3);
    check("t3_nferr", n_ferr, 0);

    // 4: framing error with line held low, then recovery
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(1'(8'h3C >> i));
    rx = 1'b0;
    repeat (40) @(negedge clk);
    check("t4_nferr", n_ferr, 1);
    check("t4_nvalid", n_valid, 3);
    check("t4_data_hold", {24'd0, data_out}, 32'hFF);
    check("t4_busy_low_line", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    check("t4_busy_released", {31'd0, busy}, 32'd0);
    send_byte(8'h11);
    repeat (4) @(negedge clk);
    check("t4_nvalid_after", n_valid, 4);
    check("t4_data_after", {24'd0, vlog[3]}, 32'h11);

    // 5: reset in the middle of data bit 4 of 0x77
    v0 = n_valid;
    f0 = n_ferr;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'h77 >> i));
    rx = 1'b1;
    repeat (8) @(negedge clk);
    check("t5_busy_pre", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_data", {24'd0, data_out}, 32'h00);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_valid", {31'd0, valid}, 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("t5_no_pulses", (n_valid - v0) + (n_ferr - f0), 0);
    send_byte(8'h5A);
    repeat (4) @(negedge clk);
    check("t5_nvalid", n_valid, v0 + 1);
    check("t5_data", {24'd0, vlog[4]}, 32'h5A);

    // 6: 0x00 with a 1-clock high glitch on the bit-2 decision sample
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    rx = 1'b0;
    repeat (8) @(negedge clk);
    rx = 1'b1;
    @(negedge clk);
    rx = 1'b0;
    repeat (7) @(negedge clk);
    for (int i = 3; i < 8; i++) drive_bit(glitch_byte[i]);
    drive_bit(1'b1);
    repeat (4) @(negedge clk);
    check("t6_nvalid", n_valid, v0 + 2);
    check("t6_data", {24'd0, vlog[5]}, {24'd0, c_GLITCH_EXP});
    check("t6_nferr", n_ferr, f0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

`default_nettype wire
